sipo_rx: RTL and testbench
==========================

// Module: sipo_rx
// PURPOSE
//   Serial-in, parallel-out receiver: the far end of the 4-bit left-shift link.
//   Collects a serial stream (MSB first, one bit per sin_valid cycle) into
//   WIDTH-bit words and presents each word on q with a valid/ready handshake.
//   A one-deep output holding register decouples assembly from the consumer.
//   Overrun and an abort input cover link faults.
// PARAMETERS
//   WIDTH      4   bits per word (>=2)
//   MSB_FIRST  1   1: first bit received lands in q[WIDTH-1]; 0: first bit lands in q[0]
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   sin        in   1        serial data bit
//   sin_valid  in   1        sin carries a bit this cycle
//   abort      in   1        discard the partially assembled word
//   q          out  WIDTH    received word (holding register)
//   q_valid    out  1        q holds an unconsumed word
//   q_ready    in   1        consumer accepts q when q_valid & q_ready
//   bit_cnt    out  clog2(WIDTH+1)  bits collected in the current word
//   busy       out  1        FSM in SHIFT (partial word held)
//   overrun    out  1        one-cycle pulse: completed word dropped
// BEHAVIOUR
//   Reset (rst=1 at posedge): q=0, q_valid=0, bit_cnt=0, busy=0, overrun=0,
//     shift reg=0, FSM=IDLE. Reset overrides all other inputs, including mid-word.
//   FSM: IDLE (bit_cnt==0) -> SHIFT on sin_valid; SHIFT -> IDLE on the WIDTH-th
//     bit or abort. busy = (state==SHIFT).
//   Shift: MSB_FIRST=1 -> sr <= {sr[WIDTH-2:0], sin}; MSB_FIRST=0 -> sr <= {sin, sr[WIDTH-1:1]}.
//     bit_cnt increments on each sin_valid, wraps to 0 on completion.
//   Completion: the cycle sin_valid delivers bit WIDTH, the assembled word
//     (including that bit) is the completed word.
//     - If the holding reg is free (q_valid=0) or drained this cycle
//       (q_valid & q_ready): q <= word, q_valid <= 1 at the next edge.
//       Latency: 1 clk from the last bit to q_valid.
//     - Otherwise: word dropped, q/q_valid unchanged, overrun=1 for 1 cycle.
//   Handshake: q_valid stays high and q stays stable until q_valid & q_ready.
//     A transfer without a simultaneous completion clears q_valid next cycle.
//     q_ready while q_valid=0 has no effect.
//   Abort: in the abort cycle any sin_valid bit is ignored. bit_cnt <= 0,
//     sr <= 0, FSM -> IDLE. The holding register and q_valid are untouched.
//     Abort in IDLE is a no-op.
//   Back-to-back: a bit may arrive every cycle; the first bit of the next word is
//     accepted in the cycle after completion, with no bubble.
//   sin is ignored when sin_valid=0. overrun is cleared every cycle unless re-asserted.
// TESTING (WIDTH=4, MSB_FIRST=1 unless stated)
//   1. Reset mid-word: 2 bits in, rst=1 -> bit_cnt=0, busy=0, q=0, q_valid=0.
//      Next 4 bits 1,1,0,0 -> q=4'hC.
//   2. Bits 1,0,1,1 on consecutive cycles, q_ready=1 -> q=4'hB, q_valid=1 exactly
//      1 clk after the 4th bit; dropped the next cycle.
//   3. Gapped input: 1,_,0,_,_,0,1 (_ = sin_valid=0) -> q=4'h9; bit_cnt steps 1,2,3,0.
//   4. q_ready=0, send 4'hA then 4'h5 -> q stays 4'hA, overrun pulses once on the
//      5's last bit. Then q_ready=1 -> q_valid falls next cycle.
//   5. q_valid=1 with q_ready=1 in the same cycle as completion of 4'h3
//      -> q=4'h3, q_valid stays 1, no overrun.
//   6. Abort after 3 bits (with sin_valid=1 in the abort cycle), then 0,1,1,0
//      -> q=4'h6. Repeat with MSB_FIRST=0 and bits 0,1,1,0 -> q=4'h6.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words from a bit stream
// and offers each word through a one-deep valid/ready holding register.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       abort,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    input  logic                       q_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       busy,
    output logic                       overrun
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_sr;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_q;
    logic              r_q_valid;
    logic              r_busy;
    logic              r_overrun;

    logic [WIDTH-1:0]  w_sr_next;
    logic              w_drain;
    logic              w_last;

    always_comb begin
        w_sr_next = '0;
        if (MSB_FIRST)
            w_sr_next = {r_sr[WIDTH-2:0], sin};
        else
            w_sr_next = {sin, r_sr[WIDTH-1:1]};
        w_drain = r_q_valid & q_ready;
        w_last  = (r_cnt == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_drain)
                r_q_valid <= 1'b0;

            // Abort wins over a coincident bit; the holding register is left alone.
            if (abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_sr    <= '0;
                r_cnt   <= '0;
            end else if (sin_valid) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_sr    <= '0;
                    r_cnt   <= '0;
                    if (!r_q_valid || w_drain) begin
                        r_q       <= w_sr_next;
                        r_q_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_state <= SHIFT;
                    r_busy  <= 1'b1;
                    r_sr    <= w_sr_next;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign bit_cnt = r_cnt;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: per-cycle vector table plus hand sequences for
// abort and LSB-first ordering (second instance with MSB_FIRST=0).
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst, sin, sin_valid, abort, q_ready;
    logic [3:0] q, q_l;
    logic       q_valid, q_valid_l, busy, busy_l, overrun, overrun_l;
    logic [2:0] bit_cnt, bit_cnt_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .abort(abort),
        .q(q), .q_valid(q_valid), .q_ready(q_ready), .bit_cnt(bit_cnt),
        .busy(busy), .overrun(overrun)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .abort(abort),
        .q(q_l), .q_valid(q_valid_l), .q_ready(q_ready), .bit_cnt(bit_cnt_l),
        .busy(busy_l), .overrun(overrun_l)
    );

    typedef struct {
        logic       rst, sin, sv, ab, rdy;
        logic [3:0] q;
        logic       v;
        logic [2:0] cnt;
        logic       busy, ov;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic sv, input logic ab,
                       input logic rdy, input logic [3:0] eq, input logic ev,
                       input logic [2:0] ec, input logic eb, input logic eo);
        vec_t t;
        t.rst = r; t.sin = s; t.sv = sv; t.ab = ab; t.rdy = rdy;
        t.q = eq; t.v = ev; t.cnt = ec; t.busy = eb; t.ov = eo;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic sv, input logic ab,
                        input logic rdy);
        rst = r; sin = s; sin_valid = sv; abort = ab; q_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; abort = 1'b0; q_ready = 1'b0;

        //   rst sin sv ab rdy   q    v  cnt busy ov
        add(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);   // reset state
        // reset mid-word, then 1,1,0,0 -> C
        add(0, 1, 1, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 1, 1, 0, 1, 4'h0, 0, 2, 1, 0);
        add(1, 1, 1, 0, 1, 4'h0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 1, 1, 0, 1, 4'h0, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 4'h0, 0, 3, 1, 0);
        add(0, 0, 1, 0, 1, 4'hC, 1, 0, 0, 0);
        // 1,0,1,1 with ready -> B one clock after the last bit, then consumed
        add(0, 1, 1, 0, 1, 4'hC, 0, 1, 1, 0);
        add(0, 0, 1, 0, 1, 4'hC, 0, 2, 1, 0);
        add(0, 1, 1, 0, 1, 4'hC, 0, 3, 1, 0);
        add(0, 1, 1, 0, 1, 4'hB, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 4'hB, 0, 0, 0, 0);
        // gapped 1,_,0,_,_,0,1 -> 9 (sin toggled while invalid)
        add(0, 1, 1, 0, 0, 4'hB, 0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 4'hB, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 4'hB, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0, 4'hB, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0, 4'hB, 0, 2, 1, 0);
        add(0, 0, 1, 0, 0, 4'hB, 0, 3, 1, 0);
        add(0, 1, 1, 0, 0, 4'h9, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 4'h9, 0, 0, 0, 0);
        // A then 5 with no ready: 5 dropped with one overrun pulse
        add(0, 1, 1, 0, 0, 4'h9, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 4'h9, 0, 2, 1, 0);
        add(0, 1, 1, 0, 0, 4'h9, 0, 3, 1, 0);
        add(0, 0, 1, 0, 0, 4'hA, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 4'hA, 1, 1, 1, 0);
        add(0, 1, 1, 0, 0, 4'hA, 1, 2, 1, 0);
        add(0, 0, 1, 0, 0, 4'hA, 1, 3, 1, 0);
        add(0, 1, 1, 0, 0, 4'hA, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 4'hA, 0, 0, 0, 0);
        // 7 held, then 3 completes in the same cycle 7 is consumed
        add(0, 0, 1, 0, 0, 4'hA, 0, 1, 1, 0);
        add(0, 1, 1, 0, 0, 4'hA, 0, 2, 1, 0);
        add(0, 1, 1, 0, 0, 4'hA, 0, 3, 1, 0);
        add(0, 1, 1, 0, 0, 4'h7, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 4'h7, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 4'h7, 1, 2, 1, 0);
        add(0, 1, 1, 0, 0, 4'h7, 1, 3, 1, 0);
        add(0, 1, 1, 0, 1, 4'h3, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 4'h3, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].sin, tbl[i].sv, tbl[i].ab, tbl[i].rdy);
            chk("q",       i, int'(q),       int'(tbl[i].q));
            chk("q_valid", i, int'(q_valid), int'(tbl[i].v));
            chk("bit_cnt", i, int'(bit_cnt), int'(tbl[i].cnt));
            chk("busy",    i, int'(busy),    int'(tbl[i].busy));
            chk("overrun", i, int'(overrun), int'(tbl[i].ov));
        end

        // Abort after 3 bits with a valid bit in the abort cycle, then 0,1,1,0
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("pre_abort_cnt", 100, int'(bit_cnt), 3);
        step(0, 1, 1, 1, 0);
        chk("abort_cnt",  101, int'(bit_cnt), 0);
        chk("abort_busy", 101, int'(busy), 0);
        chk("abort_qv",   101, int'(q_valid), 0);
        chk("abort_q",    101, int'(q), 3);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("post_abort_cnt", 102, int'(bit_cnt), 3);
        step(0, 0, 1, 0, 0);
        chk("abort_word_msb",   103, int'(q), 6);
        chk("abort_word_lsb",   103, int'(q_l), 6);
        chk("abort_word_qv",    103, int'(q_valid), 1);
        chk("abort_word_lsbqv", 103, int'(q_valid_l), 1);

        // Abort while a word is held leaves the holding register intact
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("abort_hold_q",   104, int'(q), 6);
        chk("abort_hold_qv",  104, int'(q_valid), 1);
        chk("abort_hold_cnt", 104, int'(bit_cnt), 0);
        step(0, 0, 0, 0, 1);
        chk("drain_qv", 105, int'(q_valid), 0);

        // Bit order: 1,0,0,0 -> 8 MSB-first, 1 LSB-first
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("order_msb", 106, int'(q), 8);
        chk("order_lsb", 106, int'(q_l), 1);
        chk("order_lsb_cnt", 106, int'(bit_cnt_l), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
